// File: rtl/muldiv_issue_if.sv
// rtl/muldiv_issue_if.sv - multiplier start/done handshake bundle between EX issue logic and the multiplier
interface muldiv_issue_if;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic [2:0]  mul_sign;
    logic        mul_start;
    logic        mul_done;
    logic [63:0] mul_product;

    modport master (
        output mul_a,
        output mul_b,
        output mul_sign,
        output mul_start,
        input  mul_done,
        input  mul_product
    );

    modport slave (
        input  mul_a,
        input  mul_b,
        input  mul_sign,
        input  mul_start,
        output mul_done,
        output mul_product
    );
endinterface

// File: rtl/muldiv_issue.sv
// rtl/muldiv_issue.sv - EX-stage multiply issue FSM with flush drain and watchdog; optional result reuse under MULDIV_ISSUE_REUSE_EN
module muldiv_issue #(
    parameter int MAX_LAT = 64,
    parameter int CNT_W   = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    input  logic [2:0]          req_funct3,
    input  logic [31:0]         req_rs1,
    input  logic [31:0]         req_rs2,
    input  logic                flush,
    output logic                stall,
    output logic                resp_valid,
    output logic [31:0]         resp_data,
    output logic                err,
    muldiv_issue_if.master      mul_if
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    state_t             state_q, state_d;
    logic [31:0]        mul_a_q, mul_a_d;
    logic [31:0]        mul_b_q, mul_b_d;
    logic [2:0]         mul_sign_q, mul_sign_d;
    logic               mul_start_q, mul_start_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               timeout;

    // mul returns the low word; every other multiply mode returns the high word
    function automatic logic [31:0] sel_word(input logic [1:0] f3_lo, input logic [63:0] prod);
        return (f3_lo == 2'b00) ? prod[31:0] : prod[63:32];
    endfunction

    assign cnt_inc = cnt_q + CNT_W'(1);
    // >= so a flush landing on the limit cycle still trips the watchdog in DRAIN
    assign timeout = (cnt_inc >= CNT_W'(MAX_LAT));

    assign mul_if.mul_a     = mul_a_q;
    assign mul_if.mul_b     = mul_b_q;
    assign mul_if.mul_sign  = mul_sign_q;
    assign mul_if.mul_start = mul_start_q;
    assign resp_valid       = resp_valid_q;
    assign resp_data        = resp_data_q;
    assign err              = err_q;

`ifdef MULDIV_ISSUE_REUSE_EN
    logic               tag_valid_q, tag_valid_d;
    logic [1:0]         tag_f3_q, tag_f3_d;
    logic [31:0]        tag_rs1_q, tag_rs1_d;
    logic [31:0]        tag_rs2_q, tag_rs2_d;
    logic [63:0]        tag_prod_q, tag_prod_d;
    logic               reuse_hit;

    // low word is sign-independent; high words only reuse on an identical mode
    assign reuse_hit = tag_valid_q && (req_rs1 == tag_rs1_q) && (req_rs2 == tag_rs2_q) &&
                       ((req_funct3[1:0] == 2'b00) || (req_funct3[1:0] == tag_f3_q));

    // last-completed-product tag storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_q <= 1'b0;
            tag_f3_q    <= 2'b00;
            tag_rs1_q   <= 32'h0;
            tag_rs2_q   <= 32'h0;
            tag_prod_q  <= 64'h0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_f3_q    <= tag_f3_d;
            tag_rs1_q   <= tag_rs1_d;
            tag_rs2_q   <= tag_rs2_d;
            tag_prod_q  <= tag_prod_d;
        end
    end
`endif

    // state and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            mul_a_q      <= 32'h0;
            mul_b_q      <= 32'h0;
            mul_sign_q   <= 3'b000;
            mul_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            mul_sign_q   <= mul_sign_d;
            mul_start_q  <= mul_start_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
        end
    end

    // next-state, stall and register updates
    always_comb begin
        state_d      = state_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        mul_sign_d   = mul_sign_q;
        mul_start_d  = mul_start_q;
        resp_valid_d = 1'b0;
        resp_data_d  = resp_data_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        stall        = 1'b0;
`ifdef MULDIV_ISSUE_REUSE_EN
        tag_valid_d  = tag_valid_q;
        tag_f3_d     = tag_f3_q;
        tag_rs1_d    = tag_rs1_q;
        tag_rs2_d    = tag_rs2_q;
        tag_prod_d   = tag_prod_q;
`endif
        case (state_q)
            IDLE: begin
                // resp_valid_q here means a watchdog response is on the bus; let it drain first
                if (req_valid && !req_funct3[2] && !flush && !resp_valid_q) begin
                    stall      = 1'b1;
                    mul_a_d    = req_rs1;
                    mul_b_d    = req_rs2;
                    mul_sign_d = req_funct3;
                    cnt_d      = '0;
`ifdef MULDIV_ISSUE_REUSE_EN
                    if (reuse_hit) begin
                        resp_data_d  = sel_word(req_funct3[1:0], tag_prod_q);
                        resp_valid_d = 1'b1;
                        state_d      = RESP;
                    end else begin
                        mul_start_d = 1'b1;
                        state_d     = BUSY;
                    end
`else
                    mul_start_d = 1'b1;
                    state_d     = BUSY;
`endif
                end
            end
            BUSY: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (flush) begin
                    // a done arriving with the flush is simply dropped; otherwise wait it out
                    mul_start_d = !mul_if.mul_done;
                    state_d     = mul_if.mul_done ? IDLE : DRAIN;
`ifdef MULDIV_ISSUE_REUSE_EN
                    tag_valid_d = 1'b0;
`endif
                end else if (mul_if.mul_done) begin
                    resp_data_d  = sel_word(mul_sign_q[1:0], mul_if.mul_product);
                    resp_valid_d = 1'b1;
                    mul_start_d  = 1'b0;
                    state_d      = RESP;
`ifdef MULDIV_ISSUE_REUSE_EN
                    tag_valid_d  = 1'b1;
                    tag_f3_d     = mul_sign_q[1:0];
                    tag_rs1_d    = mul_a_q;
                    tag_rs2_d    = mul_b_q;
                    tag_prod_d   = mul_if.mul_product;
`endif
                end else if (timeout) begin
                    err_d        = 1'b1;
                    mul_start_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = 32'h0;
                    state_d      = IDLE;
`ifdef MULDIV_ISSUE_REUSE_EN
                    tag_valid_d  = 1'b0;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            DRAIN: begin
                stall = req_valid;
                cnt_d = cnt_inc;
                if (mul_if.mul_done) begin
                    mul_start_d = 1'b0;
                    state_d     = IDLE;
                end else if (timeout) begin
                    err_d        = 1'b1;
                    mul_start_d  = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_data_d  = 32'h0;
                    state_d      = IDLE;
`ifdef MULDIV_ISSUE_REUSE_EN
                    tag_valid_d  = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_muldiv_issue.sv
// tb/tb_muldiv_issue.sv - directed self-checking bench for muldiv_issue
module tb_muldiv_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        flush;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          sc;
    logic        rv;
    logic [31:0] rd;

    muldiv_issue_if mif();

    muldiv_issue dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .flush      (flush),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .err        (err),
        .mul_if     (mif.master)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    // drive one request; the multiplier pulses done `lat` cycles after acceptance
    task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input int lat, input logic [63:0] prod,
                         output int stall_cnt, output logic rv_o, output logic [31:0] rd_o);
        stall_cnt  = 0;
        req_valid  = 1'b1;
        req_funct3 = f3;
        req_rs1    = a;
        req_rs2    = b;
        flush      = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            mif.mul_done    = (k == lat);
            mif.mul_product = (k == lat) ? prod : 64'h0;
            settle;
            if (stall) stall_cnt++;
            tick;
        end
        mif.mul_done    = 1'b0;
        mif.mul_product = 64'h0;
        req_valid       = 1'b0;
        settle;
        rv_o = resp_valid;
        rd_o = resp_data;
        if (stall) stall_cnt++;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b0; req_valid = 1'b0; req_funct3 = 3'b000; req_rs1 = 32'h0; req_rs2 = 32'h0;
        flush = 1'b0; mif.mul_done = 1'b0; mif.mul_product = 64'h0;
        tick; tick;
        rst = 1'b1;
        settle;
        n_checks++; if ({stall, resp_valid, err, mif.mul_start} !== 4'b0000) begin n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {stall, resp_valid, err, mif.mul_start}); end
        n_checks++; if (resp_data !== 32'h0) begin n_fail++;
            $display("FAIL reset_resp_data: got %h expected 00000000", resp_data); end
        n_checks++; if ({mif.mul_a, mif.mul_b, mif.mul_sign} !== 67'h0) begin n_fail++;
            $display("FAIL reset_operands: got %h expected 0", {mif.mul_a, mif.mul_b, mif.mul_sign}); end
    endtask

    task automatic test_single_mul;
        do_op(3'b000, 32'hFFFFFFF9, 32'd6, 4, 64'hFFFFFFFF_FFFFFFD6, sc, rv, rd);
        n_checks++; if (sc !== 5) begin n_fail++; $display("FAIL single_stall_cycles: got %0d expected 5", sc); end
        n_checks++; if (rv !== 1'b1) begin n_fail++; $display("FAIL single_resp_valid: got %b expected 1", rv); end
        n_checks++; if (rd !== 32'hFFFFFFD6) begin n_fail++; $display("FAIL single_resp_data: got %h expected ffffffd6", rd); end
        settle;
        n_checks++; if ({mif.mul_start, resp_valid} !== 2'b00) begin n_fail++;
            $display("FAIL single_after: start/resp_valid got %b expected 00", {mif.mul_start, resp_valid}); end
    endtask

    task automatic test_high_words;
        do_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 64'hFFFFFFFE_00000001, sc, rv, rd);
        n_checks++; if ({rv, rd} !== {1'b1, 32'hFFFFFFFE}) begin n_fail++; $display("FAIL mulhu: got %b/%h expected 1/fffffffe", rv, rd); end
        n_checks++; if (sc !== 2) begin n_fail++; $display("FAIL mulhu_stall_cycles: got %0d expected 2", sc); end
        do_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, 64'h00000000_00000001, sc, rv, rd);
        n_checks++; if ({rv, rd} !== {1'b1, 32'h00000000}) begin n_fail++; $display("FAIL mulh: got %b/%h expected 1/00000000", rv, rd); end
        do_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 3, 64'hFFFFFFFF_00000001, sc, rv, rd);
        n_checks++; if ({rv, rd} !== {1'b1, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL mulhsu: got %b/%h expected 1/ffffffff", rv, rd); end
    endtask

    task automatic test_div_ignored;
        req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'd1; req_rs2 = 32'd2;
        settle;
        n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL div_stall: got %b expected 0", stall); end
        tick;
        settle;
        n_checks++; if ({mif.mul_start, resp_valid} !== 2'b00) begin n_fail++;
            $display("FAIL div_no_issue: start/resp_valid got %b expected 00", {mif.mul_start, resp_valid}); end
        req_valid = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        do_op(3'b000, 32'd3, 32'd5, 2, 64'd15, sc, rv, rd);
        n_checks++; if ({rv, rd} !== {1'b1, 32'd15}) begin n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/0000000f", rv, rd); end
        settle;
        n_checks++; if (mif.mul_start !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_start: got %b expected 0", mif.mul_start); end
        do_op(3'b011, 32'h80000000, 32'd4, 1, 64'h00000002_00000000, sc, rv, rd);
        n_checks++; if ({rv, rd, sc} !== {1'b1, 32'd2, 32'd2}) begin n_fail++;
            $display("FAIL b2b_second: got %b/%h/%0d expected 1/00000002/2", rv, rd, sc); end
    endtask

    task automatic test_flush_drain;
        logic seen_rv;
        seen_rv = 1'b0;
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h11; req_rs2 = 32'h22; flush = 1'b0;
        mif.mul_done = 1'b0;
        settle; tick;
        settle;
        n_checks++; if ({mif.mul_start, mif.mul_a, mif.mul_b} !== {1'b1, 32'h11, 32'h22}) begin n_fail++;
            $display("FAIL drain_issue: got %b/%h/%h expected 1/00000011/00000022", mif.mul_start, mif.mul_a, mif.mul_b); end
        tick;
        flush = 1'b1; req_valid = 1'b0;
        settle; seen_rv |= resp_valid; tick;
        flush = 1'b0;
        settle; seen_rv |= resp_valid;
        n_checks++; if ({mif.mul_start, stall} !== 2'b10) begin n_fail++;
            $display("FAIL drain_hold: start/stall got %b expected 10", {mif.mul_start, stall}); end
        tick;
        req_valid = 1'b1; req_rs1 = 32'h33; req_rs2 = 32'h44;
        settle; seen_rv |= resp_valid;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL drain_new_req_stall: got %b expected 1", stall); end
        tick;
        mif.mul_done = 1'b1; mif.mul_product = 64'hDEAD_BEEF_DEAD_BEEF;
        settle; seen_rv |= resp_valid; tick;
        mif.mul_done = 1'b0; mif.mul_product = 64'h0;
        settle; seen_rv |= resp_valid;
        n_checks++; if ({stall, mif.mul_start} !== 2'b10) begin n_fail++;
            $display("FAIL drain_accept_after_idle: stall/start got %b expected 10", {stall, mif.mul_start}); end
        tick;
        settle;
        n_checks++; if ({mif.mul_start, mif.mul_a} !== {1'b1, 32'h33}) begin n_fail++;
            $display("FAIL drain_second_issue: got %b/%h expected 1/00000033", mif.mul_start, mif.mul_a); end
        mif.mul_done = 1'b1; mif.mul_product = 64'h0000_0D8C;
        settle; seen_rv |= resp_valid; tick;
        mif.mul_done = 1'b0; mif.mul_product = 64'h0; req_valid = 1'b0;
        settle;
        n_checks++; if ({resp_valid, resp_data} !== {1'b1, 32'h0D8C}) begin n_fail++;
            $display("FAIL drain_second_resp: got %b/%h expected 1/00000d8c", resp_valid, resp_data); end
        n_checks++; if (seen_rv !== 1'b0) begin n_fail++; $display("FAIL drain_no_resp: got %b expected 0", seen_rv); end
        tick;
    endtask

    task automatic test_flush_done_same;
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h55; req_rs2 = 32'h66;
        settle; tick;
        flush = 1'b1; req_valid = 1'b0; mif.mul_done = 1'b1; mif.mul_product = 64'h1234;
        settle; tick;
        flush = 1'b0; mif.mul_done = 1'b0; mif.mul_product = 64'h0;
        settle;
        n_checks++; if ({resp_valid, mif.mul_start, stall} !== 3'b000) begin n_fail++;
            $display("FAIL flush_done: resp_valid/start/stall got %b expected 000", {resp_valid, mif.mul_start, stall}); end
        tick;
        settle;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL flush_done_later: got %b expected 0", resp_valid); end
        tick;
    endtask

`ifdef MULDIV_ISSUE_REUSE_EN
    task automatic test_reuse;
        logic start_seen;
        do_op(3'b001, 32'h12345678, 32'h9ABCDEF0, 3, 64'hF8CC93D6_242D2080, sc, rv, rd);
        n_checks++; if ({rv, rd} !== {1'b1, 32'hF8CC93D6}) begin n_fail++; $display("FAIL reuse_mulh: got %b/%h expected 1/f8cc93d6", rv, rd); end
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h12345678; req_rs2 = 32'h9ABCDEF0;
        settle;
        start_seen = mif.mul_start;
        n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL reuse_accept_stall: got %b expected 1", stall); end
        tick;
        req_valid = 1'b0;
        settle;
        start_seen |= mif.mul_start;
        n_checks++; if ({resp_valid, resp_data} !== {1'b1, 32'h242D2080}) begin n_fail++;
            $display("FAIL reuse_mul: got %b/%h expected 1/242d2080", resp_valid, resp_data); end
        tick;
        settle;
        start_seen |= mif.mul_start;
        n_checks++; if (start_seen !== 1'b0) begin n_fail++; $display("FAIL reuse_no_start: got %b expected 0", start_seen); end
        tick;
    endtask
`endif

    task automatic test_watchdog;
        int err_cycle;
        err_cycle = -1;
        req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'd5; req_rs2 = 32'd7;
        mif.mul_done = 1'b0;
        settle; tick;
        for (int c = 1; c <= 70; c++) begin
            settle;
            if (err) begin
                err_cycle = c;
                break;
            end
            tick;
        end
        n_checks++; if (err_cycle !== 65) begin n_fail++;
            $display("FAIL watchdog_cycle: err seen at cycle %0d expected 65 (-1 = never)", err_cycle); end
        n_checks++; if ({resp_valid, resp_data, stall, mif.mul_start} !== {1'b1, 32'h0, 1'b0, 1'b0}) begin n_fail++;
            $display("FAIL watchdog_resp: got %b/%h/%b/%b expected 1/00000000/0/0", resp_valid, resp_data, stall, mif.mul_start); end
        req_valid = 1'b0;
        tick;
        settle;
        n_checks++; if ({err, resp_valid} !== 2'b10) begin n_fail++;
            $display("FAIL watchdog_sticky: err/resp_valid got %b expected 10", {err, resp_valid}); end
        tick;
    endtask

    task automatic test_async_reset;
        req_valid = 1'b1; req_funct3 = 3'b011; req_rs1 = 32'd9; req_rs2 = 32'd9;
        settle; tick;
        settle;
        n_checks++; if (mif.mul_start !== 1'b1) begin n_fail++; $display("FAIL areset_busy: got %b expected 1", mif.mul_start); end
        #2;
        rst = 1'b0; req_valid = 1'b0;
        #1;
        n_checks++; if ({mif.mul_start, err, stall, resp_valid} !== 4'b0000) begin n_fail++;
            $display("FAIL areset_flags: got %b expected 0000", {mif.mul_start, err, stall, resp_valid}); end
        n_checks++; if ({mif.mul_a, mif.mul_b, mif.mul_sign} !== 67'h0) begin n_fail++;
            $display("FAIL areset_operands: got %h expected 0", {mif.mul_a, mif.mul_b, mif.mul_sign}); end
        tick;
        rst = 1'b1;
        mif.mul_done = 1'b1; mif.mul_product = 64'hFFFF_FFFF_FFFF_FFFF;
        settle; tick;
        mif.mul_done = 1'b0; mif.mul_product = 64'h0;
        settle;
        n_checks++; if ({resp_valid, mif.mul_start} !== 2'b00) begin n_fail++;
            $display("FAIL areset_stray_done: resp_valid/start got %b expected 00", {resp_valid, mif.mul_start}); end
        tick;
        settle;
        n_checks++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL areset_stray_later: got %b expected 0", resp_valid); end
    endtask

    initial begin
        test_reset;
        test_single_mul;
        test_high_words;
        test_div_ignored;
        test_back_to_back;
        test_flush_drain;
        test_flush_done_same;
`ifdef MULDIV_ISSUE_REUSE_EN
        test_reuse;
`endif
        test_watchdog;
        test_async_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
